// File: rtl/ring_fifo_pkg.sv
// Shared sizing and pointer types for the in-order queues (ROB, LSQ, fetch buffer).
// Any block that compares queue ages works on ring_ptr_t.
package ring_fifo_pkg;

    localparam int ROB_DEPTH      = 40;
    localparam int ROB_PTR_WIDTH  = 6;
    localparam int ROB_DATA_WIDTH = 32;

    localparam int LSQ_DEPTH      = 24;
    localparam int LSQ_PTR_WIDTH  = 5;
    localparam int LSQ_DATA_WIDTH = 64;

    localparam int FB_DEPTH       = 12;
    localparam int FB_PTR_WIDTH   = 4;
    localparam int FB_DATA_WIDTH  = 32;

    // Widest index among the queues above, so one struct type serves them all.
    localparam int RING_IDX_W = 6;

    typedef struct packed {
        logic                  phase;
        logic [RING_IDX_W-1:0] idx;
    } ring_ptr_t;

    // True when a was allocated before b.
    // Both pointers must belong to the same queue and be at most one lap apart.
    function automatic logic ring_ptr_older(input ring_ptr_t a, input ring_ptr_t b);
        return (a.phase == b.phase) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/ring_fifo_ptr.sv
// Modulo-DEPTH index with a phase bit that toggles on every wrap.
// DEPTH does not have to be a power of two.
module ring_ptr
    import ring_fifo_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int PTR_WIDTH = ROB_PTR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 advance_i,
    output logic [PTR_WIDTH-1:0] idx_o,
    output logic                 phase_o,
    output logic                 at_end_o
);

    logic [PTR_WIDTH-1:0] idx_q, idx_d;
    logic                 phase_q, phase_d;

    assign at_end_o = (idx_q == PTR_WIDTH'(DEPTH - 1));
    assign idx_o    = idx_q;
    assign phase_o  = phase_q;

    always_comb begin
        idx_d   = idx_q;
        phase_d = phase_q;
        if (clear_i) begin
            idx_d   = '0;
            phase_d = 1'b0;
        end else if (advance_i) begin
            if (at_end_o) begin
                idx_d   = '0;
                phase_d = ~phase_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/ring_fifo.sv
// In-order circular queue: one enqueue port, one dequeue port, first-word fall-through.
// Full and empty are derived from the head/tail phase bits, not from count_o.
module ring_fifo
    import ring_fifo_pkg::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int PTR_WIDTH  = ROB_PTR_WIDTH,
    parameter int DATA_WIDTH = ROB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  enq_valid_i,
    output logic                  enq_ready_o,
    input  logic [DATA_WIDTH-1:0] enq_data_i,
    output logic                  deq_valid_o,
    input  logic                  deq_ready_i,
    output logic [DATA_WIDTH-1:0] deq_data_o,
    output logic [PTR_WIDTH-1:0]  head_ptr_o,
    output logic [PTR_WIDTH-1:0]  tail_ptr_o,
    output logic [PTR_WIDTH:0]    count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int CNT_W = PTR_WIDTH + 1;

    if (DEPTH > 2**PTR_WIDTH || DEPTH < 2) begin : g_bad_cfg
        $error("ring_fifo: DEPTH must be in 2..2**PTR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  head_idx, tail_idx;
    logic                  head_phase, tail_phase;
    logic                  head_at_end, tail_at_end;
    logic                  enq_fire, deq_fire;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      ptr_count;

    assign empty_o     = (head_idx == tail_idx) && (head_phase == tail_phase);
    assign full_o      = (head_idx == tail_idx) && (head_phase != tail_phase);
    assign enq_ready_o = ~full_o;
    assign deq_valid_o = ~empty_o;

    // Flush suppresses both handshakes so nothing is written or popped that cycle.
    assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
    assign deq_fire = deq_valid_o && deq_ready_i && !flush_i;

    ring_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_head (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (flush_i),
        .advance_i (deq_fire),
        .idx_o     (head_idx),
        .phase_o   (head_phase),
        .at_end_o  (head_at_end)
    );

    ring_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_tail (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (flush_i),
        .advance_i (enq_fire),
        .idx_o     (tail_idx),
        .phase_o   (tail_phase),
        .at_end_o  (tail_at_end)
    );

    // Storage is deliberately left out of reset; the pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (!rst && enq_fire) begin
            mem_q[tail_idx] <= enq_data_i;
        end
    end

    assign deq_data_o = mem_q[head_idx];
    assign head_ptr_o = head_idx;
    assign tail_ptr_o = tail_idx;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (enq_fire && !deq_fire) begin
            count_d = count_q + 1'b1;
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    // Occupancy recomputed from the pointers; used only to cross-check the counter.
    assign ptr_count = (head_phase == tail_phase)
                     ? ({1'b0, tail_idx} - {1'b0, head_idx})
                     : (CNT_W'(DEPTH) - {1'b0, head_idx} + {1'b0, tail_idx});

    a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        count_q == ptr_count);

    a_head_in_range: assert property (@(posedge clk) disable iff (rst)
        head_idx < PTR_WIDTH'(DEPTH));

    a_tail_in_range: assert property (@(posedge clk) disable iff (rst)
        tail_idx < PTR_WIDTH'(DEPTH));

    a_head_phase_only_at_wrap: assert property (@(posedge clk) disable iff (rst)
        (deq_fire && !head_at_end) |=> (head_phase == $past(head_phase)));

    a_tail_phase_only_at_wrap: assert property (@(posedge clk) disable iff (rst)
        (enq_fire && !tail_at_end) |=> (tail_phase == $past(tail_phase)));

endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo.
// Stimulus pushes each expected payload into a scoreboard queue; a separate monitor checks dequeued data against it.
module tb_ring_fifo;

    localparam int DEPTH = 40;
    localparam int PW    = 6;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          enq_valid_i = 1'b0;
    logic          enq_ready_o;
    logic [DW-1:0] enq_data_i = '0;
    logic          deq_valid_o;
    logic          deq_ready_i = 1'b0;
    logic [DW-1:0] deq_data_o;
    logic [PW-1:0] head_ptr_o, tail_ptr_o;
    logic [PW:0]   count_o;
    logic          full_o, empty_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ring_fifo #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_ready_o (enq_ready_o),
        .enq_data_i  (enq_data_i),
        .deq_valid_o (deq_valid_o),
        .deq_ready_i (deq_ready_i),
        .deq_data_o  (deq_data_o),
        .head_ptr_o  (head_ptr_o),
        .tail_ptr_o  (tail_ptr_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every dequeue handshake must return the oldest outstanding payload.
    always @(negedge clk) begin
        if (!rst && !flush_i && deq_valid_o && deq_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("deq_unexpected", deq_data_o, 32'hFFFF_FFFF);
            end else begin
                chk("deq_data", deq_data_o, exp_q.pop_front());
            end
        end
    end

    // Holds inputs for one cycle, then returns #1 after the clock edge.
    // If the enqueue is expected to be accepted, its payload is pushed to the scoreboard.
    task automatic drive(input logic ev, input logic [31:0] d, input logic dr, input logic exp_acc);
        enq_valid_i = ev;
        enq_data_i  = d;
        deq_ready_i = dr;
        @(negedge clk);
        if (ev) begin
            chk("enq_ready", {31'd0, enq_ready_o}, {31'd0, exp_acc});
            if (exp_acc) exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_count"}, 32'(count_o), 32'd0);
        chk({tag, "_empty"}, {31'd0, empty_o}, 32'd1);
        chk({tag, "_full"}, {31'd0, full_o}, 32'd0);
        chk({tag, "_enq_ready"}, {31'd0, enq_ready_o}, 32'd1);
        chk({tag, "_deq_valid"}, {31'd0, deq_valid_o}, 32'd0);
        chk({tag, "_head"}, 32'(head_ptr_o), 32'd0);
        chk({tag, "_tail"}, 32'(tail_ptr_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_cleared("reset");

        // Fill with data 0..39; the 41st enqueue must be refused.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'(i), 1'b0, 1'b1);
        chk("fill_full", {31'd0, full_o}, 32'd1);
        chk("fill_count", 32'(count_o), 32'd40);
        chk("fill_tail", 32'(tail_ptr_o), 32'd0);
        drive(1'b1, 32'd999, 1'b0, 1'b0);
        chk("over_count", 32'(count_o), 32'd40);
        chk("over_tail", 32'(tail_ptr_o), 32'd0);

        // Drain: 0..39 in order.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drain_empty", {31'd0, empty_o}, 32'd1);
        chk("drain_head", 32'(head_ptr_o), 32'd0);
        chk("drain_count", 32'(count_o), 32'd0);

        // Move both pointers to 38, then enqueue across the wrap point.
        for (int i = 0; i < 38; i++) drive(1'b1, 32'(200 + i), 1'b0, 1'b1);
        for (int i = 0; i < 38; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("pre_wrap_tail", 32'(tail_ptr_o), 32'd38);
        chk("pre_wrap_head", 32'(head_ptr_o), 32'd38);
        begin
            logic [31:0] exp_tail [5] = '{32'd39, 32'd0, 32'd1, 32'd2, 32'd3};
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 32'(100 + i), 1'b0, 1'b1);
                chk("wrap_tail", 32'(tail_ptr_o), exp_tail[i]);
            end
        end
        chk("wrap_count", 32'(count_o), 32'd5);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("wrap_empty", {31'd0, empty_o}, 32'd1);

        // Steady stream with 3 entries resident.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(300 + i), 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 32'(303 + i), 1'b1, 1'b1);
            chk("stream_count", 32'(count_o), 32'd3);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("stream_empty", {31'd0, empty_o}, 32'd1);

        // Full with a simultaneous deq: the enqueue waits one cycle.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'(400 + i), 1'b0, 1'b1);
        chk("full2_count", 32'(count_o), 32'd40);
        drive(1'b1, 32'd500, 1'b1, 1'b0);
        chk("full_deq_count", 32'(count_o), 32'd39);
        drive(1'b1, 32'd501, 1'b0, 1'b1);
        chk("refill_count", 32'(count_o), 32'd40);
        chk("refill_full", {31'd0, full_o}, 32'd1);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("full2_empty", {31'd0, empty_o}, 32'd1);

        // Flush with 7 entries while both ports handshake.
        for (int i = 0; i < 7; i++) drive(1'b1, 32'(600 + i), 1'b0, 1'b1);
        flush_i = 1'b1;
        enq_valid_i = 1'b1;
        enq_data_i = 32'd777;
        deq_ready_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        exp_q.delete();
        chk_cleared("flush");
        drive(1'b1, 32'd800, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Reset mid-stream yields the same state as flush.
        for (int i = 0; i < 7; i++) drive(1'b1, 32'(900 + i), 1'b0, 1'b1);
        rst = 1'b1;
        enq_valid_i = 1'b1;
        enq_data_i = 32'd888;
        deq_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        exp_q.delete();
        chk_cleared("rst_mid");
        drive(1'b1, 32'd50, 1'b0, 1'b1);
        drive(1'b1, 32'd51, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("post_rst_empty", {31'd0, empty_o}, 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ring_fifo.md
Name: ring_fifo

Overview:
- Circular queue with storage, built on two modulo-DEPTH wrap pointers (head/tail), each with a phase bit.
- DEPTH is not required to be a power of two; default 40 matches the ROB/issue-queue sizing.
- Sits downstream of the wrap-counter logic and upstream of consumers that need in-order buffering: ROB, load/store queues, fetch buffer.
- Single enqueue port and single dequeue port, valid/ready handshake, first-word fall-through, synchronous flush.

Parameters:
DEPTH, 40, number of entries; wrap point is DEPTH-1
PTR_WIDTH, 6, index width; must satisfy DEPTH <= 2**PTR_WIDTH
DATA_WIDTH, 32, payload width per entry

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, synchronous, active-high
flush_i  input  1  empty the queue this cycle; overrides enq/deq
enq_valid_i  input  1  producer has data
enq_ready_o  output  1  queue can accept (= !full_o)
enq_data_i  input  DATA_WIDTH  payload written at tail
deq_valid_o  output  1  head entry valid (= !empty_o)
deq_ready_i  input  1  consumer takes head entry
deq_data_o  output  DATA_WIDTH  payload at head, combinational read
head_ptr_o  output  PTR_WIDTH  current head index
tail_ptr_o  output  PTR_WIDTH  current tail index
count_o  output  PTR_WIDTH+1  occupied entries, 0..DEPTH
full_o  output  1  count_o == DEPTH
empty_o  output  1  count_o == 0

Behaviour:
- Reset and flush: head=0, tail=0, both phase bits=0, count_o=0, empty_o=1, full_o=0, enq_ready_o=1, deq_valid_o=0. Storage is not reset.
- Enqueue fire = enq_valid_i && enq_ready_o. On fire:
  - mem[tail] <= enq_data_i.
  - tail advances: if tail==DEPTH-1 then tail<=0 and tail phase toggles, else tail<=tail+1.
- Dequeue fire = deq_valid_o && deq_ready_i. On fire, head advances with the same wrap/phase rule.
- Full/empty are derived from the pointers:
  - empty = (head==tail) && (phases equal).
  - full = (head==tail) && (phases differ).
  - count_o is a registered counter. It must always agree with the pointers; an internal assertion checks this.
- count_o update:
  - +1 on enq fire only.
  - -1 on deq fire only.
  - unchanged on both fires or neither.
- Latency:
  - An entry enqueued in cycle N is visible on deq_data_o with deq_valid_o=1 in cycle N+1.
  - No same-cycle bypass: when empty, deq_valid_o stays 0 in the enqueue cycle.
- deq_data_o = mem[head] at all times. Its value is don't-care while deq_valid_o=0.
- Boundary cases:
  - Full: enq_ready_o=0, so an enqueue is never accepted even if deq fires in the same cycle. The slot frees in the next cycle.
  - Empty: deq_valid_o=0, so deq_ready_i is ignored.
  - Simultaneous enq and deq fire on a non-full, non-empty queue: both pointers advance, count unchanged.
  - Wrap: pointer values DEPTH..2**PTR_WIDTH-1 are never reached. An assertion flags any out-of-range pointer.
- flush_i priority: overrides any enq/deq in the same cycle. Nothing is written and nothing is popped.
- rst priority: takes precedence over flush_i and all handshakes. Asserting rst mid-operation discards the contents immediately, with the same state as after flush.
- Elaboration check: error if DEPTH > 2**PTR_WIDTH or DEPTH < 2.

Decomposition:
- Shared package constants: default DEPTH/PTR_WIDTH/DATA_WIDTH per queue instance (ROB, LSQ, fetch buffer).
- Shared package typedef: a ring-pointer struct {phase bit, index}, reused by any block that compares queue ages.
- One natural sub-module: ring_ptr.
  - Modulo-DEPTH index with phase bit.
  - Inputs: advance, clear.
  - Outputs: index, phase, and an at_end flag (index==DEPTH-1).
  - Instantiated twice, for head and tail.
- Storage array and count logic live in ring_fifo itself.

Test Plan:
- Reset, then 40 back-to-back enqueues with data 0..39 and deq_ready_i=0:
  - full_o=1 after the 40th; count_o=40; enq_ready_o=0; tail_ptr_o=0.
  - A 41st enq_valid_i is not accepted.
- From full, 40 dequeues with deq_ready_i=1:
  - deq_data_o returns 0..39 in order; empty_o=1 after the last; head_ptr_o=0.
- Wrap check:
  - Enq 38 entries, deq 38, then enq 5 entries (100..104).
  - tail goes 38→39→0→1→2→3 with tail phase toggled; the FIFO drains 100..104 in order.
- Steady stream: with 3 entries held, enq and deq fire every cycle for 50 cycles.
  - count_o stays 3; data order preserved across the wrap.
- Full with deq fire and enq_valid_i=1: the deq is taken, the enq is rejected; count_o goes 40→39; the next cycle the enq is accepted, count_o=40.
- flush_i asserted with 7 entries while enq and deq both valid:
  - Next cycle count_o=0, empty_o=1, head=tail=0.
  - No entry is written or popped in the flush cycle.
  - rst mid-stream gives an identical result.
